// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared defaults for the receive-side byte FIFO.
//   FIFO_DATA_WIDTH : default stored word width in bits
//   FIFO_DEPTH      : default number of entries (power of two, >= 2)
//   FIFO_PTR_W      : pointer width derived from FIFO_DEPTH
package rx_fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_PTR_W      = $clog2(FIFO_DEPTH);
endpackage : rx_fifo_pkg

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag logic for rx_fifo.
//   clk      : system clock, rising edge
//   n_rst    : asynchronous active-low reset
//   w_enable : push request, accepted when not full
//   r_enable : pop request, accepted when not empty
//   wptr     : storage index for the next write
//   rptr     : storage index of the head entry
//   w_strobe : high when the push is accepted on the coming edge
//   empty    : no entries stored
//   full     : DEPTH entries stored
module fifo_ctrl
  import rx_fifo_pkg::*;
#(
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             w_enable,
  input  logic             r_enable,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic             w_strobe,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
  // DEPTH is a power of two, so DEPTH == 1 << PTR_W.
  localparam logic [PTR_W:0]   FULL_COUNT = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_accept_s;
  logic             r_accept_s;
  logic             empty_s;
  logic             full_s;

  // Flags decode the occupancy register only, never the enables.
  assign empty_s = (count_q == {(PTR_W+1){1'b0}});
  assign full_s  = (count_q == FULL_COUNT);

  // Accept decisions and next-state pointers/count.
  always_comb begin
    w_accept_s = w_enable & ~full_s;
    r_accept_s = r_enable & ~empty_s;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (w_accept_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (r_accept_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({w_accept_s, r_accept_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr     = wptr_q;
  assign rptr     = rptr_q;
  assign w_strobe = w_accept_s;
  assign empty    = empty_s;
  assign full     = full_s;

endmodule : fifo_ctrl

// File: rtl/rx_fifo.sv
// rx_fifo: first-word-fall-through receive FIFO.
//   clk      : system clock, rising edge
//   n_rst    : asynchronous active-low reset, clears contents and storage
//   r_enable : pop the head entry on the next edge if not empty
//   w_enable : push w_data on the next edge if not full
//   w_data   : word to push
//   r_data   : head (oldest) entry, combinational from storage
//   empty    : no entries stored
//   full     : DEPTH entries stored
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  r_enable,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wptr_s;
  logic [PTR_W-1:0]      rptr_s;
  logic                  w_strobe_s;

  fifo_ctrl #(
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk      (clk),
    .n_rst    (n_rst),
    .w_enable (w_enable),
    .r_enable (r_enable),
    .wptr     (wptr_s),
    .rptr     (rptr_s),
    .w_strobe (w_strobe_s),
    .empty    (empty),
    .full     (full)
  );

  // Next storage contents: only the addressed entry changes on an accepted write.
  always_comb begin
    mem_d = mem_q;
    if (w_strobe_s) begin
      mem_d[wptr_s] = w_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; reset clears every entry so r_data reads 0 after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads are not destructive, so a stale head stays visible when empty.
  assign r_data = mem_q[rptr_s];

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
module tb_rx_fifo;

  logic       clk;
  logic       n_rst;
  logic       r_enable;
  logic       w_enable;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty;
  logic       full;

  int checks;
  int failures;

  rx_fifo dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .r_enable (r_enable),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    w_enable = 1'b1;
    w_data   = d;
    step();
    w_enable = 1'b0;
  endtask

  task automatic pop();
    r_enable = 1'b1;
    step();
    r_enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    r_enable = 1'b0;
    w_enable = 1'b1;
    w_data   = 8'hAA;

    // Reset held across an edge with a write request.
    step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rdata", 32'(r_data), 32'h00);

    // Release and write 0xFF: visible right after the edge.
    n_rst  = 1'b1;
    w_data = 8'hFF;
    step();
    w_enable = 1'b0;
    check("ft_rdata", 32'(r_data), 32'hFF);
    check("ft_empty", 32'(empty), 32'd0);
    check("ft_full", 32'(full), 32'd0);

    // Drain it (ptrs now 1/1).
    pop();
    check("ft_drain_empty", 32'(empty), 32'd1);

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      check("fill_rdata", 32'(r_data), 32'h01);
      check("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
    end

    // Writes while full are ignored.
    for (int i = 0; i < 8; i++) begin
      push(8'h00);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_rdata", 32'(r_data), 32'h01);
    end

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      pop();
      if (i < 8) check("drain_rdata", 32'(r_data), 32'(i + 1));
      check("drain_empty", 32'(empty), (i == 8) ? 32'd1 : 32'd0);
      check("drain_full", 32'(full), 32'd0);
    end

    // Extra read on empty; the next write must become the head.
    pop();
    check("udf_empty", 32'(empty), 32'd1);
    push(8'h5A);
    check("udf_next_rdata", 32'(r_data), 32'h5A);

    // Three entries, simultaneous read+write.
    push(8'h11);
    push(8'h22);
    r_enable = 1'b1;
    w_enable = 1'b1;
    w_data   = 8'h33;
    step();
    r_enable = 1'b0;
    w_enable = 1'b0;
    check("rw3_rdata", 32'(r_data), 32'h11);
    check("rw3_empty", 32'(empty), 32'd0);
    pop();
    check("rw3_d1", 32'(r_data), 32'h22);
    pop();
    check("rw3_d2", 32'(r_data), 32'h33);
    check("rw3_d2_empty", 32'(empty), 32'd0);
    pop();
    check("rw3_d3_empty", 32'(empty), 32'd1);

    // Full with simultaneous read+write: read only.
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    check("rwf_pre_full", 32'(full), 32'd1);
    r_enable = 1'b1;
    w_enable = 1'b1;
    w_data   = 8'hEE;
    step();
    r_enable = 1'b0;
    w_enable = 1'b0;
    check("rwf_full", 32'(full), 32'd0);
    check("rwf_rdata", 32'(r_data), 32'hA1);
    for (int i = 2; i <= 7; i++) begin
      pop();
      check("rwf_drain", 32'(r_data), 32'hA0 + 32'(i));
    end
    pop();
    check("rwf_end_empty", 32'(empty), 32'd1);
    // Slot that 0xEE would have taken still holds the stale 0xA0.
    check("rwf_not_stored", 32'(r_data), 32'hA0);

    // Empty with simultaneous read+write: write only.
    r_enable = 1'b1;
    w_enable = 1'b1;
    w_data   = 8'h77;
    step();
    r_enable = 1'b0;
    w_enable = 1'b0;
    check("rwe_rdata", 32'(r_data), 32'h77);
    check("rwe_empty", 32'(empty), 32'd0);
    pop();
    check("rwe_one_entry", 32'(empty), 32'd1);

    // Wrap-around: write 5, read 5, write 8, read 8.
    for (int i = 1; i <= 5; i++) push(8'h30 + 8'(i));
    for (int i = 1; i <= 5; i++) begin
      check("wrap5_head", 32'(r_data), 32'h30 + 32'(i));
      pop();
    end
    check("wrap5_empty", 32'(empty), 32'd1);
    for (int i = 1; i <= 8; i++) push(8'h40 + 8'(i));
    check("wrap8_full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("wrap8_head", 32'(r_data), 32'h40 + 32'(i));
      pop();
    end
    check("wrap8_empty", 32'(empty), 32'd1);

    // Asynchronous reset between edges.
    push(8'h99);
    check("arst_pre_rdata", 32'(r_data), 32'h99);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_rdata", 32'(r_data), 32'h00);
    step();
    n_rst = 1'b1;
    push(8'h12);
    check("arst_post_rdata", 32'(r_data), 32'h12);
    check("arst_post_empty", 32'(empty), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rx_fifo
